// File: rtl/seq_borrow_subtractor_if.sv
// rtl/seq_borrow_subtractor_if.sv - operand/result handshake bundle for seq_borrow_subtractor
interface seq_borrow_subtractor_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] D;
  logic         Bout;
  logic         Ovf;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, Ovf
  );
endinterface

// File: rtl/seq_borrow_subtractor.sv
// rtl/seq_borrow_subtractor.sv - multi-cycle A - B - Bin, W bits per clock with chunk borrow lookahead
module seq_borrow_subtractor #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_borrow_subtractor_if.slave bus
);
  localparam int NCHUNK = N / W;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_d;
  logic           r_borrow;
  logic           r_bout;
  logic           r_ovf;
  logic           r_out_valid;
  logic [KW-1:0]  r_k;

  logic [W-1:0]   w_a_chunk;
  logic [W-1:0]   w_b_chunk;
  logic [W-1:0]   w_g;
  logic [W-1:0]   w_p;
  logic [W:0]     w_bc;
  logic [W-1:0]   w_d_chunk;
  logic           w_last;
  logic           w_accept;

  assign w_last   = (r_k == KW'(NCHUNK - 1));
  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_k == KW'(c)) begin
        w_a_chunk = r_a[c*W +: W];
        w_b_chunk = r_b[c*W +: W];
      end
    end
  end

  // w_bc[i] is the borrow into bit i, each one a flat sum of generate/propagate products
  always_comb begin
    logic v_prop;
    logic v_acc;
    logic v_term;
    v_prop = 1'b0;
    v_acc  = 1'b0;
    v_term = 1'b0;
    w_g    = ~w_a_chunk & w_b_chunk;
    w_p    = ~(w_a_chunk ^ w_b_chunk);
    w_bc   = '0;
    w_bc[0] = r_borrow;
    for (int i = 1; i <= W; i++) begin
      v_prop = r_borrow;
      for (int j = 0; j < i; j++) begin
        v_prop = v_prop & w_p[j];
      end
      v_acc = v_prop;
      for (int j = 0; j < i; j++) begin
        v_term = w_g[j];
        for (int m = j + 1; m < i; m++) begin
          v_term = v_term & w_p[m];
        end
        v_acc = v_acc | v_term;
      end
      w_bc[i] = v_acc;
    end
    w_d_chunk = w_a_chunk ^ w_b_chunk ^ w_bc[W-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)        w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_borrow    <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_k         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a      <= bus.A;
        r_b      <= bus.B;
        r_borrow <= bus.Bin;
        r_k      <= '0;
        r_d      <= '0;
        r_bout   <= 1'b0;
        r_ovf    <= 1'b0;
      end else if (r_state == S_RUN) begin
        for (int c = 0; c < NCHUNK; c++) begin
          if (r_k == KW'(c)) begin
            r_d[c*W +: W] <= w_d_chunk;
          end
        end
        r_borrow <= w_bc[W];
        if (w_last) begin
          r_bout <= w_bc[W];
          // the final chunk's top bit is D[N-1]
          r_ovf  <= (r_a[N-1] ^ r_b[N-1]) & (w_d_chunk[W-1] ^ r_a[N-1]);
          r_k    <= '0;
        end else begin
          r_k    <= r_k + KW'(1);
        end
      end
    end
  end

  // results are masked until DONE so a partially written difference never leaks out
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.D         = r_out_valid ? r_d : '0;
  assign bus.Bout      = r_out_valid & r_bout;
  assign bus.Ovf       = r_out_valid & r_ovf;
endmodule

// File: tb/tb_seq_borrow_subtractor.sv
// tb/tb_seq_borrow_subtractor.sv - randomized and directed checks of seq_borrow_subtractor
module tb_seq_borrow_subtractor;
  localparam int NB  = 32;
  localparam int WB  = 8;
  localparam int NCH = NB / WB;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  seq_borrow_subtractor_if #(.N(NB)) bus ();

  seq_borrow_subtractor #(.N(NB), .W(WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] r;
    logic        ovf;
    r   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    ovf = (a[31] != b[31]) && (r[31] != a[31]);
    return {ovf, r[32], r[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin, input int hold);
    logic [33:0] e;
    e = ref_sub(a, b, bin);
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.Bin       = bin;
    bus.out_ready = 1'b0;
    @(posedge clk);
    for (int j = 0; j < NCH; j++) begin
      @(negedge clk);
      bus.in_valid = 1'(j == 0 ? 0 : $urandom_range(0, 1));
      bus.A        = $urandom;
      bus.B        = $urandom;
      bus.Bin      = 1'($urandom_range(0, 1));
      chk("run_out_valid", 64'(bus.out_valid), 64'd0);
      chk("run_D_hidden", 64'(bus.D), 64'd0);
      chk("run_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_out_valid", 64'(bus.out_valid), 64'd1);
    chk("done_D", 64'(bus.D), 64'(e[31:0]));
    chk("done_Bout", 64'(bus.Bout), 64'(e[32]));
    chk("done_Ovf", 64'(bus.Ovf), 64'(e[33]));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = ~bus.in_valid;
      bus.A        = $urandom;
      bus.B        = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_D", 64'(bus.D), 64'(e[31:0]));
      chk("hold_Bout", 64'(bus.Bout), 64'(e[32]));
      chk("hold_Ovf", 64'(bus.Ovf), 64'(e[33]));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_D", 64'(bus.D), 64'd0);
    chk("rst_Bout", 64'(bus.Bout), 64'd0);
    chk("rst_Ovf", 64'(bus.Ovf), 64'd0);
    rst_n = 1'b1;

    run_op(32'd4565, 32'd1209, 1'b0, 0);
    run_op(32'd1209, 32'd4565, 1'b0, 0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 0);
    run_op(32'd0, 32'd0, 1'b1, 0);
    run_op(32'h0100_0000, 32'h0000_0001, 1'b0, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    run_op(32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 5);

    for (int i = 0; i < 24; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 32'd5;
    bus.B        = 32'd2;
    bus.Bin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_D", 64'(bus.D), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.out_ready = 1'b0;
    run_op(32'd10, 32'd3, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
